// File: rtl/pool1_max2x2.sv
// pool1_max2x2: 2x2 stride-2 pooling of a valid-qualified raster stream through a half-row line buffer.
// Max pooling by default; define POOL1_AVG_EN for average pooling (floor of the four-sample mean).
module pool1_max2x2 #(
  parameter int DATA_W   = 32,
  parameter int IN_WIDTH = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cnn_data_in,
  input  logic              cnn_data_in_valid,
  input  logic              img_in_en,
  output logic [DATA_W-1:0] cnn_data_out,
  output logic              cnn_data_out_valid,
  output logic              frame_done
);
  localparam int OUT_WIDTH = IN_WIDTH / 2;
  localparam int CW        = $clog2(IN_WIDTH);
`ifdef POOL1_AVG_EN
  localparam int LBW = DATA_W + 1;
`else
  localparam int LBW = DATA_W;
`endif
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

  // Handshake: a sample is taken only when cnn_data_in_valid & img_in_en; there is no
  // backpressure. cnn_data_out_valid is a one-cycle pulse per pooled pixel, and
  // cnn_data_out holds its last value between pulses.
  logic [CW-1:0]     r_col;
  logic [CW-1:0]     r_row;
  logic [DATA_W-1:0] r_pair_hold;
  logic [LBW-1:0]    r_line_buf [OUT_WIDTH];

  logic              w_acc;
  logic              w_abort;
  logic              w_col_last;
  logic              w_row_last;
  logic [CW-2:0]     w_idx;
  logic [LBW-1:0]    w_pm;
  logic [DATA_W-1:0] w_pool;

  assign w_acc      = cnn_data_in_valid & img_in_en;
  assign w_abort    = cnn_data_in_valid & ~img_in_en;
  assign w_col_last = (r_col == LAST);
  assign w_row_last = (r_row == LAST);
  assign w_idx      = r_col[CW-1:1];

`ifdef POOL1_AVG_EN
  logic [DATA_W+1:0] w_sum;
  assign w_pm   = {1'b0, r_pair_hold} + {1'b0, cnn_data_in};
  assign w_sum  = {1'b0, r_line_buf[w_idx]} + {1'b0, w_pm};
  assign w_pool = w_sum[DATA_W+1:2];
`else
  assign w_pm   = (r_pair_hold >= cnn_data_in) ? r_pair_hold : cnn_data_in;
  assign w_pool = (r_line_buf[w_idx] >= w_pm) ? r_line_buf[w_idx] : w_pm;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col              <= '0;
      r_row              <= '0;
      r_pair_hold        <= '0;
      cnn_data_out       <= '0;
      cnn_data_out_valid <= 1'b0;
      frame_done         <= 1'b0;
    end else begin
      cnn_data_out_valid <= 1'b0;
      frame_done         <= 1'b0;
      if (w_abort) begin
        // Dropping img_in_en under a valid sample restarts the frame at (0,0).
        r_col       <= '0;
        r_row       <= '0;
        r_pair_hold <= '0;
      end else if (w_acc) begin
        r_col <= w_col_last ? '0 : r_col + 1'b1;
        if (w_col_last) begin
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end
        if (!r_col[0]) begin
          r_pair_hold <= cnn_data_in;
        end else if (r_row[0]) begin
          cnn_data_out       <= w_pool;
          cnn_data_out_valid <= 1'b1;
          frame_done         <= w_row_last & w_col_last;
        end
      end
    end
  end

  // Even rows park their horizontal pair result until the odd row below arrives.
  always_ff @(posedge clk) begin
    if (w_acc && r_col[0] && !r_row[0]) begin
      r_line_buf[w_idx] <= w_pm;
    end
  end

endmodule

// File: tb/tb_pool1_max2x2.sv
// Scoreboard bench for pool1_max2x2: a reference image model predicts each pooled pixel,
// its frame_done flag and its arrival cycle; a negedge monitor pops and compares.
module tb_pool1_max2x2;
  localparam int DATA_W   = 32;
  localparam int IN_WIDTH = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] cnn_data_in = '0;
  logic              cnn_data_in_valid = 1'b0;
  logic              img_in_en = 1'b0;
  logic [DATA_W-1:0] cnn_data_out;
  logic              cnn_data_out_valid;
  logic              frame_done;

  pool1_max2x2 #(.DATA_W(DATA_W), .IN_WIDTH(IN_WIDTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cnn_data_in        (cnn_data_in),
    .cnn_data_in_valid  (cnn_data_in_valid),
    .img_in_en          (img_in_en),
    .cnn_data_out       (cnn_data_out),
    .cnn_data_out_valid (cnn_data_out_valid),
    .frame_done         (frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: {frame_done, data} and the negedge index it must appear on
  logic [DATA_W:0]   exp_q[$];
  int                due_q[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                n_neg = 0;
  logic [DATA_W-1:0] img [IN_WIDTH][IN_WIDTH];
  int                m_row = 0;
  int                m_col = 0;
  logic [DATA_W:0]   mon_exp;
  int                mon_due;

  task automatic check(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference: pooled value of the 2x2 block whose top-left corner is (r,c)
  function automatic logic [DATA_W-1:0] block_ref(input int r, input int c);
    longint unsigned v[4];
    longint unsigned m;
    v[0] = img[r][c];
    v[1] = img[r][c+1];
    v[2] = img[r+1][c];
    v[3] = img[r+1][c+1];
`ifdef POOL1_AVG_EN
    m = (v[0] + v[1] + v[2] + v[3]) / 4;
`else
    m = 0;
    for (int i = 0; i < 4; i++) if (v[i] > m) m = v[i];
`endif
    return DATA_W'(m);
  endfunction

  // driver tasks
  task automatic drive_sample(input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    cnn_data_in       = d;
    cnn_data_in_valid = 1'b1;
    img_in_en         = 1'b1;
    img[m_row][m_col] = d;
    if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
      exp_q.push_back({(m_row == IN_WIDTH-1) && (m_col == IN_WIDTH-1), block_ref(m_row-1, m_col-1)});
      due_q.push_back(n_neg + 2);
    end
    if (m_col == IN_WIDTH-1) begin
      m_col = 0;
      m_row = (m_row == IN_WIDTH-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cnn_data_in_valid = 1'b0;
      img_in_en         = 1'b1;
      cnn_data_in       = $urandom;
    end
  endtask

  task automatic abort_frame();
    @(posedge clk); #1;
    cnn_data_in_valid = 1'b1;
    img_in_en         = 1'b0;
    cnn_data_in       = $urandom;
    m_row = 0;
    m_col = 0;
  endtask

  // mode 0 ramp, 1 max placement (rotating corner), 2 random full-range
  task automatic drive_frame(input int mode, input int gap_max, input int n_samples);
    int k;
    logic [DATA_W-1:0] d;
    k = 0;
    for (int r = 0; r < IN_WIDTH; r++) begin
      for (int c = 0; c < IN_WIDTH; c++) begin
        if (k < n_samples) begin
          case (mode)
            0: d = DATA_W'(r * IN_WIDTH + c);
            1: d = ((((r / 2) * (IN_WIDTH / 2) + c / 2) % 4) == ((r % 2) * 2 + c % 2)) ? DATA_W'(1000) : '0;
            default: d = $urandom;
          endcase
          drive_sample(d);
          if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
        k++;
      end
    end
  endtask

  task automatic reset_check(input string tag);
    idle(1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_out"}, cnn_data_out, 0);
    check({tag, "_valid"}, cnn_data_out_valid, 0);
    check({tag, "_done"}, frame_done, 0);
    m_row = 0;
    m_col = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // monitor
  always @(negedge clk) begin
    n_neg++;
    if (rst_n) begin
      if (cnn_data_out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_due = due_q.pop_front();
          check("pool_data", cnn_data_out, mon_exp[DATA_W-1:0]);
          check("frame_done", frame_done, mon_exp[DATA_W]);
          check("latency", n_neg, mon_due);
        end
      end else begin
        if (frame_done) check("stray_frame_done", 1, 0);
        if (due_q.size() > 0 && due_q[0] <= n_neg) begin
          check("missing_valid", 0, 1);
          mon_exp = exp_q.pop_front();
          mon_due = due_q.pop_front();
        end
      end
    end
  end

  // stimulus sequence and final report
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", cnn_data_out, 0);
    check("reset_valid", cnn_data_out_valid, 0);
    check("reset_done", frame_done, 0);
    rst_n = 1'b1;
    idle(2);

    drive_frame(0, 0, 576);   // ramp
    drive_frame(1, 0, 576);   // back-to-back placement frame
    drive_frame(0, 0, 576);
    idle(3);
    drive_frame(0, 3, 576);   // gapped ramp
    drive_frame(2, 1, 576);   // random full-range data
    idle(2);

    drive_frame(0, 0, 100);   // abort after 100 samples
    abort_frame();
    drive_frame(0, 0, 576);
    idle(2);

    drive_frame(0, 0, 300);   // reset mid-frame
    reset_check("midreset");
    drive_frame(0, 0, 576);
    drive_frame(2, 0, 576);

    idle(6);
    check("leftover_expected", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
